// File: rtl/mips_muldiv_seq_pkg.sv
// Shared op codes, FSM states and iteration constants for the multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

endpackage

// File: rtl/mips_muldiv_seq_hl_reg.sv
// 32-bit HI/LO storage register with synchronous reset and write enable.
module hl_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mips_muldiv_seq.sv
// Iterative 32-step multiply/divide sequencer owning the CPU's HI/LO pair.
module mips_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] CNT_LOAD = (ITER == 32) ? ITER_LAST : 5'(ITER - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        sign_a;
    logic        sign_b;
    logic        div0;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] rem;
    logic [31:0] orig_a;
    logic [63:0] acc;

    logic        is_arith;
    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [32:0] sum33;
    logic [32:0] sh;
    logic [31:0] diff;
    logic        qbit;
    logic [63:0] prod;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;
    logic [31:0] hi_d;
    logic [31:0] lo_d;
    logic        hi_en;
    logic        lo_en;

    assign busy      = (state != IDLE);
    assign is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign neg_a     = is_signed & op_a[31];
    assign neg_b     = is_signed & op_b[31];

    always_comb begin
        sum33 = {1'b0, acc[63:32]} + {1'b0, (b_reg[0] ? a_reg : 32'd0)};
        sh    = {rem, a_reg[31]};
        qbit  = (sh >= {1'b0, b_reg});
        // When qbit is set the true difference fits in 32 bits, so the low word suffices.
        diff  = sh[31:0] - b_reg;
    end

    always_comb begin
        prod    = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix = (sign_a ^ sign_b) ? -a_reg : a_reg;
        rem_fix = sign_a ? -rem : rem;
        if (!is_div) begin
            hi_fix = prod[63:32];
            lo_fix = prod[31:0];
        end else if (div0) begin
            hi_fix = orig_a;
            lo_fix = '1;
        end else begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end
    end

    always_comb begin
        hi_d  = (state == FIX) ? hi_fix : op_a;
        lo_d  = (state == FIX) ? lo_fix : op_a;
        hi_en = clk_enable & ((state == FIX) | ((state == IDLE) & start & (op == OP_MTHI)));
        lo_en = clk_enable & ((state == FIX) | ((state == IDLE) & start & (op == OP_MTLO)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            rem    <= '0;
            orig_a <= '0;
            acc    <= '0;
        end else if (clk_enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_arith) begin
                        is_div <= op[1];
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        a_reg  <= neg_a ? -op_a : op_a;
                        b_reg  <= neg_b ? -op_b : op_b;
                        orig_a <= op_a;
                        div0   <= (op_b == 32'd0);
                        acc    <= '0;
                        rem    <= '0;
                        cnt    <= CNT_LOAD;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem   <= qbit ? diff : sh[31:0];
                        a_reg <= {a_reg[30:0], qbit};
                    end else begin
                        acc   <= {sum33, acc[31:1]};
                        b_reg <= {1'b0, b_reg[31:1]};
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    hl_reg u_hi (
        .clk    (clk),
        .reset  (reset),
        .enable (hi_en),
        .d      (hi_d),
        .q      (hi)
    );

    hl_reg u_lo (
        .clk    (clk),
        .reset  (reset),
        .enable (lo_en),
        .d      (lo_d),
        .q      (lo)
    );

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Scoreboard bench for mips_muldiv_seq: expected HI/LO queued at issue, compared at done.
module tb_mips_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];

    mips_muldiv_seq #(.ITER(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference {hi, lo} from plain language arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        int sa, sb;
        int q, r;
        case (o)
            OP_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int drop_at, input int drop_len);
        int   edges;
        logic got;
        logic busy_ok;
        logic [63:0] e;
        sb_q.push_back(model(o, a, b));
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL accept op%0d: got busy=%b done=%b expected busy=1 done=0", o, busy, done);
        end
        edges = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && edges < 200) begin
            if (drop_len > 0 && edges == drop_at) begin
                clk_enable = 1'b0;
                repeat (drop_len) begin
                    @(posedge clk); #1;
                    edges++;
                    if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
                end
                clk_enable = 1'b1;
            end
            @(posedge clk); #1;
            edges++;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL busy_window op%0d: got busy drop before done expected busy held", o);
        end
        vectors++;
        if (!got || edges != 33 + drop_len) begin
            miscompares++;
            $display("FAIL latency op%0d: got %0d edges (done=%b) expected %0d", o, edges, got, 33 + drop_len);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_clear op%0d: got %b expected 0", o, busy);
        end
        e = sb_q.pop_front();
        vectors++;
        if ({hi, lo} !== e) begin
            miscompares++;
            $display("FAIL result op%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                     o, a, b, hi, lo, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_mult();
        run_arith(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0);
        run_arith(OP_MULT, 32'hFFFFFFFD, 32'd7, -1, 0);
    endtask

    task automatic test_div();
        run_arith(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, 0);
        run_arith(OP_DIVU, 32'd100, 32'd0, -1, 0);
        run_arith(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 0);
        run_arith(OP_DIV, 32'hFFFFFFF0, 32'd0, -1, 0);
    endtask

    task automatic test_mt();
        logic [31:0] hi_prev;
        @(posedge clk); #1;
        start = 1'b1; op = OP_MTHI; op_a = 32'h12345678;
        @(posedge clk); #1;
        vectors++;
        if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: got hi=%h busy=%b done=%b expected hi=12345678 busy=0 done=0", hi, busy, done);
        end
        op = OP_MTLO; op_a = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if ({hi, lo} !== 64'h12345678_9ABCDEF0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected 12345678 9abcdef0 0 0", hi, lo, busy, done);
        end
        hi_prev = hi;
        start = 1'b1; op = 3'd7; op_a = 32'hDEADBEEF; op_b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== hi_prev || lo !== 32'h9ABCDEF0) begin
            miscompares++;
            $display("FAIL undef_op: got busy=%b hi=%h lo=%h expected 0 %h 9abcdef0", busy, hi, lo, hi_prev);
        end
    endtask

    task automatic test_abort();
        logic saw_done;
        start = 1'b1; op = OP_DIVU; op_a = 32'd10; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = OP_MULTU; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL abort: got busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL abort_quiet: got done/busy activity expected none");
        end
        run_arith(OP_DIVU, 32'd10, 32'd3, -1, 0);
    endtask

    task automatic test_clk_enable();
        run_arith(OP_MULTU, 32'd6, 32'd7, 10, 5);
        clk_enable = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (done !== 1'b1 || lo !== 32'h2A) begin
            miscompares++;
            $display("FAIL done_hold: got done=%b lo=%h expected done=1 lo=0000002a", done, lo);
        end
        clk_enable = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int unsigned i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 9)) : $urandom);
            if (i == 6) a = 32'h80000000;
            run_arith(o, a, b, -1, 0);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL final_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_abort();
        test_clk_enable();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
